dispense_controller: RTL and testbench
======================================

Name: dispense_controller

Overview:
Sequences the physical output stage after payment is accepted: drives one product motor for a fixed time, then pays change through a three-tube coin hopper ($10/$5/$1) using a four-phase req/ack handshake. It sits between the vending FSM, which issues a start pulse on entry to its dispatch state, and the motor and hopper drivers. It exports the remaining change and a status code for the seven-segment display path.

Parameters:
MOTOR_CYCLES, 1000, clk cycles motor_on is held per dispense (min 1)
ACK_TIMEOUT, 255, max clk cycles waiting on any hopper_ack edge before fault (min 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low
start  input  1  single-cycle request; sampled only in IDLE
product  input  3  product code, valid 1..5
total  input  8  unsigned price x quantity, $
paid  input  8  unsigned amount entered, $
fault_clr  input  1  clears FAULT, returns to IDLE
hopper_ack  input  1  hopper acknowledge (four-phase)
motor_on  output  1  motor enable
motor_sel  output  5  one-hot motor select, bit (product-1)
hopper_req  output  3  one-hot coin request: bit2=$10, bit1=$5, bit0=$1
busy  output  1  high in any state except IDLE and FAULT
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on rejected start
fault  output  1  level, high while in FAULT
change_left  output  8  change still owed, $
status  output  3  state code for display

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; latched registers 0.
- All outputs registered; transitions on posedge clk.
- States/codes: IDLE=0, CHECK=1, MOTOR=2, CHG_SEL=3, CHG_REQ=4, CHG_REL=5, DONE=6, FAULT=7; status = code.
- IDLE: start=1 -> latch product/total/paid -> CHECK. start in any other state is ignored.
- CHECK (1 cycle): product not in 1..5, or paid<total -> err=1 for one cycle -> IDLE; no motor or coin activity. Otherwise change_left=paid-total (8-bit, no wrap possible) -> MOTOR.
- MOTOR: motor_sel one-hot, motor_on=1 for exactly MOTOR_CYCLES cycles -> CHG_SEL; both drop to 0 on exit.
- CHG_SEL (1 cycle, greedy): change_left>=10 -> coin $10; else >=5 -> $5; else >=1 -> $1; else change_left==0 -> DONE. A coin selection -> CHG_REQ.
- CHG_REQ: hopper_req one-hot held until hopper_ack=1; on ack, drop req, subtract coin value from change_left -> CHG_REL.
- CHG_REL: wait hopper_ack=0 -> CHG_SEL.
- Timeout counter resets on entry to CHG_REQ and CHG_REL; reaching ACK_TIMEOUT cycles without the awaited edge -> FAULT with hopper_req=0 and change_left frozen.
- hopper_ack already 1 on entry to CHG_REQ: treated as ack on the first cycle. Requires a preceding CHG_REL low phase, so it can only follow a timeout-free release.
- DONE (1 cycle): done=1 -> IDLE.
- FAULT: fault=1, busy=0; fault_clr -> IDLE with change_left cleared. start is ignored in FAULT.
- Coin count is bounded: max change $255 = 25x$10 + 1x$5 + 0x$1 = 26 coins.

Decomposition:
- vending_pkg: state encodings, coin values (10/5/1), product code range, hopper_req bit positions.
- Sub-module hopper_handshake: one coin request through the four-phase req/ack protocol with timeout. Interface: go, coin[2:0], hopper_req, hopper_ack, ok pulse, timeout pulse.
- The parent holds the FSM, motor timer, and change arithmetic.

Test Plan:
- product=1, total=6, paid=6, MOTOR_CYCLES=4 -> motor_sel=00001 and motor_on high exactly 4 cycles, no hopper_req, done pulse, status returns to 0.
- product=3, total=5, paid=23, ack responder 2-cycle latency -> coin sequence $10,$5,$1,$1,$1; change_left steps 18,8,3,2,1,0; then done.
- product=2, total=10, paid=9 -> err pulse one cycle after start, motor_on never asserted, back in IDLE.
- product=6, paid>=total -> err pulse, no dispense; then start with product=0 -> same result.
- paid=15, total=0, hopper never acks, ACK_TIMEOUT=8 -> hopper_req=100 for 8 cycles, then fault=1, status=7, change_left=15. fault_clr -> IDLE, change_left=0.
- reset asserted low mid-MOTOR and mid-CHG_REQ -> motor_on, hopper_req, busy drop immediately (async). After release, status=0 and a second start is accepted normally.

Source files
------------

// File: rtl/dispense_controller_pkg.sv
// Shared encodings for the dispense controller: FSM states, coin values,
// hopper request bit positions and the latched order payload.
package dispense_controller_pkg;

    localparam int unsigned PRICE_W   = 8;
    localparam int unsigned PRODUCT_W = 3;
    localparam int unsigned MOTOR_N   = 5;
    localparam int unsigned COIN_N    = 3;
    localparam int unsigned STATUS_W  = 3;

    localparam int unsigned REQ_10_BIT = 2;
    localparam int unsigned REQ_5_BIT  = 1;
    localparam int unsigned REQ_1_BIT  = 0;

    localparam logic [COIN_N-1:0] REQ_10 = COIN_N'(1 << REQ_10_BIT);
    localparam logic [COIN_N-1:0] REQ_5  = COIN_N'(1 << REQ_5_BIT);
    localparam logic [COIN_N-1:0] REQ_1  = COIN_N'(1 << REQ_1_BIT);

    localparam logic [PRICE_W-1:0] COIN_10_VAL = PRICE_W'(10);
    localparam logic [PRICE_W-1:0] COIN_5_VAL  = PRICE_W'(5);
    localparam logic [PRICE_W-1:0] COIN_1_VAL  = PRICE_W'(1);

    localparam logic [PRODUCT_W-1:0] PRODUCT_MIN = PRODUCT_W'(1);
    localparam logic [PRODUCT_W-1:0] PRODUCT_MAX = PRODUCT_W'(5);

    typedef enum logic [STATUS_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_MOTOR   = 3'd2,
        ST_CHG_SEL = 3'd3,
        ST_CHG_REQ = 3'd4,
        ST_CHG_REL = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAULT   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_REL  = 2'd2
    } hs_phase_e;

    typedef struct packed {
        logic [PRODUCT_W-1:0] product;
        logic [PRICE_W-1:0]   total;
        logic [PRICE_W-1:0]   paid;
    } order_t;

    function automatic logic [PRICE_W-1:0] coin_value(input logic [COIN_N-1:0] req);
        case (req)
            REQ_10:  return COIN_10_VAL;
            REQ_5:   return COIN_5_VAL;
            REQ_1:   return COIN_1_VAL;
            default: return '0;
        endcase
    endfunction

    function automatic logic [MOTOR_N-1:0] motor_onehot(input logic [PRODUCT_W-1:0] product);
        return MOTOR_N'(1) << (product - PRODUCT_MIN);
    endfunction

endpackage

// File: rtl/dispense_controller_if.sv
// Bundle between the vending FSM / output drivers (master) and the dispense controller (slave).
interface dispense_controller_if;
    import dispense_controller_pkg::*;

    logic                 start;
    logic [PRODUCT_W-1:0] product;
    logic [PRICE_W-1:0]   total;
    logic [PRICE_W-1:0]   paid;
    logic                 fault_clr;
    logic                 hopper_ack;
    logic                 motor_on;
    logic [MOTOR_N-1:0]   motor_sel;
    logic [COIN_N-1:0]    hopper_req;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 fault;
    logic [PRICE_W-1:0]   change_left;
    logic [STATUS_W-1:0]  status;

    modport master (
        output start, product, total, paid, fault_clr, hopper_ack,
        input  motor_on, motor_sel, hopper_req, busy, done, err, fault, change_left, status
    );

    modport slave (
        input  start, product, total, paid, fault_clr, hopper_ack,
        output motor_on, motor_sel, hopper_req, busy, done, err, fault, change_left, status
    );

endinterface

// File: rtl/dispense_controller_hopper_handshake.sv
// One coin request through the four-phase req/ack protocol, with a per-phase
// timeout. Event outputs are combinational so the parent FSM moves in lock-step.
module dispense_controller_hopper_handshake
    import dispense_controller_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_go,
    input  logic [COIN_N-1:0] i_coin,
    input  logic              i_hopper_ack,
    output logic [COIN_N-1:0] o_hopper_req,
    output logic              o_ack_c,
    output logic              o_ok_c,
    output logic              o_timeout_c
);

    localparam int unsigned TCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    hs_phase_e         r_phase;
    hs_phase_e         w_phase_nxt;
    logic [TCW-1:0]    r_cnt;
    logic [COIN_N-1:0] r_req;
    logic              w_expired;

    assign w_expired    = (r_cnt == TCW'(ACK_TIMEOUT - 1));
    assign o_hopper_req = r_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= HS_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        o_ack_c     = 1'b0;
        o_ok_c      = 1'b0;
        o_timeout_c = 1'b0;
        case (r_phase)
            HS_IDLE: begin
                if (i_go) w_phase_nxt = HS_REQ;
            end
            HS_REQ: begin
                if (i_hopper_ack) begin
                    o_ack_c     = 1'b1;
                    w_phase_nxt = HS_REL;
                end else if (w_expired) begin
                    o_timeout_c = 1'b1;
                    w_phase_nxt = HS_IDLE;
                end
            end
            HS_REL: begin
                if (!i_hopper_ack) begin
                    o_ok_c      = 1'b1;
                    w_phase_nxt = HS_IDLE;
                end else if (w_expired) begin
                    o_timeout_c = 1'b1;
                    w_phase_nxt = HS_IDLE;
                end
            end
            default: w_phase_nxt = HS_IDLE;
        endcase
    end

    // Counter restarts on every phase change, so each awaited edge gets a full budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_req <= '0;
        end else begin
            if (r_phase != HS_IDLE && w_phase_nxt == r_phase) r_cnt <= r_cnt + TCW'(1);
            else                                              r_cnt <= '0;
            if (r_phase == HS_IDLE && i_go) r_req <= i_coin;
            else if (w_phase_nxt != HS_REQ) r_req <= '0;
        end
    end

endmodule

// File: rtl/dispense_controller.sv
// Post-payment output sequencer: runs the product motor for a fixed time,
// then pays change greedily through the $10/$5/$1 hopper.
module dispense_controller
    import dispense_controller_pkg::*;
#(
    parameter int unsigned MOTOR_CYCLES = 1000,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    dispense_controller_if.slave bus
);

    localparam int unsigned MCW = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;

    state_e             r_state;
    state_e             w_state_nxt;
    order_t             r_order;
    logic [MCW-1:0]     r_motor_cnt;
    logic [PRICE_W-1:0] r_change;
    logic [COIN_N-1:0]  r_coin;
    logic               r_motor_on;
    logic [MOTOR_N-1:0] r_motor_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_fault;
    logic [COIN_N-1:0]  w_coin;
    logic               w_go;
    logic               w_err;
    logic               w_order_ok;
    logic [COIN_N-1:0]  w_hopper_req;
    logic               w_ack;
    logic               w_ok;
    logic               w_timeout;

    assign w_order_ok = (r_order.product >= PRODUCT_MIN) && (r_order.product <= PRODUCT_MAX)
                     && (r_order.paid >= r_order.total);

    dispense_controller_hopper_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_hopper (
        .clk          (clk),
        .reset        (reset),
        .i_go         (w_go),
        .i_coin       (w_coin),
        .i_hopper_ack (bus.hopper_ack),
        .o_hopper_req (w_hopper_req),
        .o_ack_c      (w_ack),
        .o_ok_c       (w_ok),
        .o_timeout_c  (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_coin      = '0;
        w_go        = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_order_ok) begin
                    w_state_nxt = ST_MOTOR;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOTOR: begin
                if (r_motor_cnt == MCW'(MOTOR_CYCLES - 1)) w_state_nxt = ST_CHG_SEL;
            end
            ST_CHG_SEL: begin
                if (r_change >= COIN_10_VAL)     w_coin = REQ_10;
                else if (r_change >= COIN_5_VAL) w_coin = REQ_5;
                else if (r_change != '0)         w_coin = REQ_1;
                if (w_coin != '0) begin
                    w_go        = 1'b1;
                    w_state_nxt = ST_CHG_REQ;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_CHG_REQ: begin
                if (w_ack)          w_state_nxt = ST_CHG_REL;
                else if (w_timeout) w_state_nxt = ST_FAULT;
            end
            ST_CHG_REL: begin
                if (w_ok)           w_state_nxt = ST_CHG_SEL;
                else if (w_timeout) w_state_nxt = ST_FAULT;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_FAULT: begin
                if (bus.fault_clr) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_order     <= '0;
            r_motor_cnt <= '0;
            r_change    <= '0;
            r_coin      <= '0;
            r_motor_on  <= 1'b0;
            r_motor_sel <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_motor_on  <= (w_state_nxt == ST_MOTOR);
            r_motor_sel <= (w_state_nxt == ST_MOTOR) ? motor_onehot(r_order.product) : '0;
            r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FAULT);
            r_done      <= (w_state_nxt == ST_DONE);
            r_fault     <= (w_state_nxt == ST_FAULT);
            r_err       <= w_err;

            if (r_state == ST_IDLE && bus.start)
                r_order <= '{product: bus.product, total: bus.total, paid: bus.paid};

            if (r_state == ST_MOTOR && w_state_nxt == ST_MOTOR) r_motor_cnt <= r_motor_cnt + MCW'(1);
            else                                                r_motor_cnt <= '0;

            if (w_go) r_coin <= w_coin;

            if (r_state == ST_CHECK && w_order_ok)
                r_change <= r_order.paid - r_order.total;
            else if (r_state == ST_CHG_REQ && w_ack)
                r_change <= r_change - coin_value(r_coin);
            else if (r_state == ST_FAULT && bus.fault_clr)
                r_change <= '0;
        end
    end

    assign bus.status      = r_state;
    assign bus.motor_on    = r_motor_on;
    assign bus.motor_sel   = r_motor_sel;
    assign bus.hopper_req  = w_hopper_req;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.fault       = r_fault;
    assign bus.change_left = r_change;

endmodule

// File: tb/tb_dispense_controller.sv
// Directed + randomized bench for dispense_controller against a transaction-level
// model of the dispense/change rules, with a four-phase hopper responder.
module tb_dispense_controller;

    localparam int unsigned MOTOR_CYCLES = 4;
    localparam int unsigned ACK_TIMEOUT  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dispense_controller_if bus();

    dispense_controller #(
        .MOTOR_CYCLES (MOTOR_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int         cyc = 0;
    int         start_cyc, motor_first, err_cyc;
    int         motor_cnt, req_cycles, done_cnt, err_cnt;
    logic [4:0] motor_sel_or;
    logic [2:0] prev_req;
    bit         saw_fault;
    logic [2:0] coin_q[$];
    logic [7:0] chg_q[$];

    bit ack_en;
    int ack_lat;
    int ack_wait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observer: records what the DUT did during one transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.start) start_cyc = cyc;
            if (bus.motor_on) begin
                if (motor_cnt == 0) motor_first = cyc;
                motor_cnt++;
            end
            motor_sel_or = motor_sel_or | bus.motor_sel;
            if (bus.hopper_req != 3'b000 && prev_req == 3'b000) begin
                coin_q.push_back(bus.hopper_req);
                chg_q.push_back(bus.change_left);
            end
            if (bus.hopper_req != 3'b000) req_cycles++;
            prev_req = bus.hopper_req;
            if (bus.done) done_cnt++;
            if (bus.err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bus.fault) saw_fault = 1'b1;
            cyc++;
        end
    end

    // Hopper model: ack follows req after ack_lat extra cycles in both phases.
    initial begin
        bus.hopper_ack = 1'b0;
        ack_wait       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!ack_en) begin
                bus.hopper_ack = 1'b0;
                ack_wait       = 0;
            end else if ((bus.hopper_req != 3'b000) != bus.hopper_ack) begin
                if (ack_wait >= ack_lat) begin
                    bus.hopper_ack = ~bus.hopper_ack;
                    ack_wait       = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic clear_mon();
        motor_cnt    = 0;
        req_cycles   = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        motor_sel_or = '0;
        prev_req     = '0;
        saw_fault    = 1'b0;
        start_cyc    = 0;
        motor_first  = 0;
        err_cyc      = 0;
        coin_q.delete();
        chg_q.delete();
    endtask

    task automatic start_txn(input logic [2:0] p, input logic [7:0] t, input logic [7:0] pd);
        clear_mon();
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.product = p;
        bus.total   = t;
        bus.paid    = pd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] p, input logic [7:0] t, input logic [7:0] pd);
        bit         ok;
        bit         fin;
        int         chg;
        int         rem;
        logic [2:0] exp_coins[$];
        logic [7:0] exp_chg[$];
        ok  = (p >= 3'd1) && (p <= 3'd5) && (pd >= t);
        chg = ok ? (int'(pd) - int'(t)) : 0;
        rem = chg;
        for (int k = 0; k < chg / 10; k++)       begin exp_chg.push_back(8'(rem)); exp_coins.push_back(3'b100); rem -= 10; end
        for (int k = 0; k < (chg % 10) / 5; k++) begin exp_chg.push_back(8'(rem)); exp_coins.push_back(3'b010); rem -= 5;  end
        for (int k = 0; k < chg % 5; k++)        begin exp_chg.push_back(8'(rem)); exp_coins.push_back(3'b001); rem -= 1;  end

        start_txn(p, t, pd);
        fin = 1'b0;
        for (int i = 0; i < 1000 && !fin; i++) begin
            @(negedge clk);
            #1;
            fin = (done_cnt + err_cnt != 0) || saw_fault;
        end
        check("txn_complete", 32'(fin), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        check("err_pulse",    err_cnt,   ok ? 0 : 1);
        check("done_pulse",   done_cnt,  ok ? 1 : 0);
        check("motor_cycles", motor_cnt, ok ? MOTOR_CYCLES : 0);
        check("motor_sel",    32'(motor_sel_or), ok ? 32'(5'b00001 << (p - 3'd1)) : 32'd0);
        if (ok) check("motor_latency", motor_first - start_cyc, 2);
        else    check("err_latency",   err_cyc - start_cyc, 2);
        check("coin_count", coin_q.size(), exp_coins.size());
        for (int k = 0; k < exp_coins.size() && k < coin_q.size(); k++) begin
            check("coin",        32'(coin_q[k]), 32'(exp_coins[k]));
            check("change_step", 32'(chg_q[k]),  32'(exp_chg[k]));
        end
        check("final_status", 32'(bus.status),      32'd0);
        check("final_change", 32'(bus.change_left), 32'd0);
        check("final_busy",   32'(bus.busy),        32'd0);
    endtask

    initial begin
        bit         fin;
        logic [2:0] rp;
        logic [7:0] rt;
        logic [7:0] rpd;

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.product   = '0;
        bus.total     = '0;
        bus.paid      = '0;
        bus.fault_clr = 1'b0;
        ack_en        = 1'b1;
        ack_lat       = 1;
        clear_mon();

        #23;
        check("rst_status",   32'(bus.status),      32'd0);
        check("rst_busy",     32'(bus.busy),        32'd0);
        check("rst_motor_on", 32'(bus.motor_on),    32'd0);
        check("rst_req",      32'(bus.hopper_req),  32'd0);
        check("rst_change",   32'(bus.change_left), 32'd0);
        check("rst_flags",    32'({bus.done, bus.err, bus.fault}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Exact payment, no change.
        run_txn(3'd1, 8'd6, 8'd6);
        // $18 change with a slower hopper.
        ack_lat = 2;
        run_txn(3'd3, 8'd5, 8'd23);
        // Rejected orders: underpaid, product out of range on both sides.
        run_txn(3'd2, 8'd10, 8'd9);
        run_txn(3'd6, 8'd3, 8'd9);
        run_txn(3'd0, 8'd3, 8'd9);

        // Hopper never acknowledges: timeout into FAULT, then clear.
        ack_en = 1'b0;
        start_txn(3'd2, 8'd0, 8'd15);
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            #1;
            fin = saw_fault;
        end
        check("fault_reached",  32'(fin),             32'd1);
        check("fault_req_cyc",  req_cycles,           ACK_TIMEOUT);
        check("fault_coin",     coin_q.size() > 0 ? 32'(coin_q[0]) : 32'd0, 32'd4);
        check("fault_level",    32'(bus.fault),       32'd1);
        check("fault_status",   32'(bus.status),      32'd7);
        check("fault_change",   32'(bus.change_left), 32'd15);
        check("fault_busy",     32'(bus.busy),        32'd0);
        check("fault_req_drop", 32'(bus.hopper_req),  32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("fault_ignores_start", 32'(bus.status), 32'd7);
        @(posedge clk);
        #1;
        bus.fault_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.fault_clr = 1'b0;
        @(negedge clk);
        check("clr_status", 32'(bus.status),      32'd0);
        check("clr_change", 32'(bus.change_left), 32'd0);
        check("clr_fault",  32'(bus.fault),       32'd0);
        ack_en = 1'b1;

        // Asynchronous reset in the middle of the motor run.
        start_txn(3'd4, 8'd3, 8'd20);
        fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            #1;
            fin = bus.motor_on;
        end
        check("reached_motor", 32'(fin), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_motor_on",  32'(bus.motor_on),  32'd0);
        check("arst_motor_sel", 32'(bus.motor_sel), 32'd0);
        check("arst_busy",      32'(bus.busy),      32'd0);
        check("arst_status",    32'(bus.status),    32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset while a coin request is outstanding.
        ack_en = 1'b0;
        start_txn(3'd1, 8'd0, 8'd7);
        fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            #1;
            fin = (bus.hopper_req != 3'b000);
        end
        check("reached_req", 32'(fin), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req",    32'(bus.hopper_req),  32'd0);
        check("arst_busy2",  32'(bus.busy),        32'd0);
        check("arst_change", 32'(bus.change_left), 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        ack_en = 1'b1;
        run_txn(3'd5, 8'd12, 8'd40);

        // Randomized orders, roughly a quarter with random (often short) payment.
        for (int n = 0; n < 16; n++) begin
            ack_lat = $urandom_range(0, 3);
            rp      = 3'($urandom_range(0, 7));
            rpd     = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rt = 8'($urandom_range(0, 255));
            else                           rt = 8'($urandom_range(0, int'(rpd)));
            run_txn(rp, rt, rpd);
        end
        run_txn(3'd5, 8'd0, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
